rr_pri_encoder: RTL and testbench

- Parametrised N-to-log2(N) priority encoder with a registered output and a valid/ready output handshake.
- Two modes: fixed priority (highest index wins, the classic encoder behaviour) and round-robin (rotating priority pointer).
- Sits between a request vector (interrupt lines, arbiter requests) and a single consumer of the winning index.
- Supersedes the combinational 8-to-3 encoder in new designs.

---
 rtl/rr_pri_encoder_pkg.sv | 11 +
 rtl/rr_pri_encoder_pri_search.sv | 17 +
 rtl/rr_pri_encoder.sv | 44 ++++
 tb/tb_rr_pri_encoder.sv | 121 ++++++++++++
 4 files changed

// File: rtl/rr_pri_encoder_pkg.sv
// rr_pri_encoder_pkg: shared mode constants and clog2 helper for priority encoders and arbiters
package rr_pri_encoder_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_pri_encoder_pri_search.sv
// pri_search: combinational highest-set-index search with found flag
module pri_search
  import rr_pri_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] req,
  output logic [W-1:0] idx,
  output logic         found
);
  always_comb begin
    idx = '0;
    for (int i = 0; i < N; i++) if (req[i]) idx = W'(i);
  end
  assign found = |req;
endmodule

// File: rtl/rr_pri_encoder.sv
// rr_pri_encoder: registered fixed/round-robin priority encoder with valid/ready output
module rr_pri_encoder
  import rr_pri_encoder_pkg::*;
#(
  parameter  int N    = 8,
  localparam int IDXW = clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            mode,
  input  logic            out_ready,
  output logic [IDXW-1:0] idx,
  output logic [N-1:0]    grant,
  output logic            valid
);
  logic [IDXW-1:0] ptr, ptr_next, sp, sidx, win;
  logic [N-1:0] rot;
  logic mode_q, found, accept, capture;
  assign accept   = valid & out_ready;
  assign capture  = ~valid | out_ready;
  assign ptr_next = (accept && mode_q == MODE_RR) ? (idx == '0 ? IDXW'(N - 1) : idx - IDXW'(1)) : ptr;
  assign sp       = (mode == MODE_RR) ? ptr_next : IDXW'(N - 1);
  assign rot      = N'({req, req} >> (int'(sp) + 1));
  pri_search #(.N(N)) u_search (.req(rot), .idx(sidx), .found(found));
  assign win      = IDXW'((int'(sidx) + int'(sp) + 1) % N);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      idx    <= '0;
      grant  <= '0;
      ptr    <= IDXW'(N - 1);
      mode_q <= MODE_FIXED;
    end else begin
      ptr <= ptr_next;
      if (capture) begin
        valid  <= found;
        idx    <= found ? win : '0;
        grant  <= found ? N'(1) << win : '0;
        mode_q <= mode;
      end
    end
  end
endmodule

// File: tb/tb_rr_pri_encoder.sv
// tb_rr_pri_encoder: directed self-checking bench for rr_pri_encoder (N=8 and N=5)
module tb_rr_pri_encoder;
  logic clk, rst_n;
  logic [7:0] req8, grant8;
  logic [2:0] idx8;
  logic mode8, rdy8, valid8;
  logic [4:0] req5, grant5;
  logic [2:0] idx5;
  logic mode5, rdy5, valid5;
  int vecs, errs;

  rr_pri_encoder #(.N(8)) d8 (.clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .out_ready(rdy8),
                              .idx(idx8), .grant(grant8), .valid(valid8));
  rr_pri_encoder #(.N(5)) d5 (.clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .out_ready(rdy5),
                              .idx(idx5), .grant(grant5), .valid(valid5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp8(input string tag, input logic v, input logic [2:0] i, input logic [7:0] g);
    chk({tag, ".valid"}, 32'(v), 32'(valid8));
    chk({tag, ".valid"}, 32'(valid8), 32'(v));
    chk({tag, ".idx"}, 32'(idx8), 32'(i));
    chk({tag, ".grant"}, 32'(grant8), 32'(g));
  endtask

  task automatic exp5(input string tag, input logic v, input logic [2:0] i, input logic [4:0] g);
    chk({tag, ".valid"}, 32'(valid5), 32'(v));
    chk({tag, ".idx"}, 32'(idx5), 32'(i));
    chk({tag, ".grant"}, 32'(grant5), 32'(g));
  endtask

  task automatic do_reset;
    #2 rst_n = 1'b0;
    #1;
    exp8("async_rst8", 1'b0, 3'd0, 8'h00);
    exp5("async_rst5", 1'b0, 3'd0, 5'h00);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst_n = 1'b0;
    req8 = 8'h00; mode8 = 1'b0; rdy8 = 1'b1;
    req5 = 5'h00; mode5 = 1'b1; rdy5 = 1'b1;
    #3;
    exp8("rst8", 1'b0, 3'd0, 8'h00);
    #4 rst_n = 1'b1;
    req8 = 8'hFF; mode8 = 1'b1;
    tick; exp8("post_rst_rr", 1'b1, 3'd7, 8'h80);
    tick; exp8("post_rst_rr2", 1'b1, 3'd6, 8'h40);
    do_reset;
    mode8 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      req8 = 8'h01 << i;
      tick; exp8("fixed_sweep", 1'b1, 3'(i), 8'h01 << i);
    end
    req8 = 8'h00;
    tick; exp8("fixed_empty", 1'b0, 3'd0, 8'h00);
    req8 = 8'b1010_0101;
    for (int i = 0; i < 4; i++) begin
      tick; exp8("fixed_multi", 1'b1, 3'd7, 8'h80);
    end
    mode8 = 1'b1;
    tick; exp8("fixed_to_rr", 1'b1, 3'd7, 8'h80);
    do_reset;
    req8 = 8'hFF; mode8 = 1'b1;
    tick; exp8("rr_ff7", 1'b1, 3'd7, 8'h80);
    tick; exp8("rr_ff6", 1'b1, 3'd6, 8'h40);
    tick; exp8("rr_ff5", 1'b1, 3'd5, 8'h20);
    tick; exp8("rr_ff4", 1'b1, 3'd4, 8'h10);
    tick; exp8("rr_ff3", 1'b1, 3'd3, 8'h08);
    tick; exp8("rr_ff2", 1'b1, 3'd2, 8'h04);
    tick; exp8("rr_ff1", 1'b1, 3'd1, 8'h02);
    tick; exp8("rr_ff0", 1'b1, 3'd0, 8'h01);
    tick; exp8("rr_ffwrap", 1'b1, 3'd7, 8'h80);
    req8 = 8'b0001_0010;
    tick; exp8("rr_alt_a", 1'b1, 3'd4, 8'h10);
    tick; exp8("rr_alt_b", 1'b1, 3'd1, 8'h02);
    tick; exp8("rr_alt_c", 1'b1, 3'd4, 8'h10);
    tick; exp8("rr_alt_d", 1'b1, 3'd1, 8'h02);
    do_reset;
    mode8 = 1'b0; req8 = 8'h20;
    tick; exp8("stall_load", 1'b1, 3'd5, 8'h20);
    rdy8 = 1'b0; req8 = 8'h01; mode8 = 1'b1;
    tick; exp8("stall1", 1'b1, 3'd5, 8'h20);
    tick; exp8("stall2", 1'b1, 3'd5, 8'h20);
    tick; exp8("stall3", 1'b1, 3'd5, 8'h20);
    rdy8 = 1'b1;
    tick; exp8("stall_release", 1'b1, 3'd0, 8'h01);
    req8 = 8'h00;
    do_reset;
    req5 = 5'b11111; mode5 = 1'b1; rdy5 = 1'b1;
    tick; exp5("n5_4", 1'b1, 3'd4, 5'h10);
    tick; exp5("n5_3", 1'b1, 3'd3, 5'h08);
    tick; exp5("n5_2", 1'b1, 3'd2, 5'h04);
    tick; exp5("n5_1", 1'b1, 3'd1, 5'h02);
    tick; exp5("n5_0", 1'b1, 3'd0, 5'h01);
    tick; exp5("n5_wrap", 1'b1, 3'd4, 5'h10);
    tick; exp5("n5_3b", 1'b1, 3'd3, 5'h08);
    do_reset;
    tick; exp5("n5_restart", 1'b1, 3'd4, 5'h10);
    tick; exp5("n5_restart2", 1'b1, 3'd3, 5'h08);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
